// File: rtl/freelist_pkg.sv
// Shared constants, types and pointer helpers for the physical-register free list.
package freelist_pkg;

    localparam int unsigned NUM_PREG = 64;
    localparam int unsigned NUM_LREG = 32;
    localparam int unsigned DEPTH    = NUM_PREG - NUM_LREG;
    localparam int unsigned PREG_W   = $clog2(NUM_PREG);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    // Index plus one wrap bit, so full and empty are distinguishable.
    localparam int unsigned PTR_W    = IDX_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;
    typedef logic [IDX_W-1:0]  fl_idx_t;

    // Advance a pointer by 0..2; DEPTH is a power of two, so natural overflow
    // of the PTR_W-bit sum carries into the wrap bit.
    function automatic fl_ptr_t ptr_add(input fl_ptr_t ptr, input logic [1:0] inc);
        return ptr + fl_ptr_t'(inc);
    endfunction

    function automatic fl_idx_t ptr_idx(input fl_ptr_t ptr);
        return ptr[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/freelist.sv
// Circular free list of physical registers: speculative head pops on rename,
// tail pushes released pregs at commit, architectural head restores on flush.
module freelist
    import freelist_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    instr0_freelist_req,
    output preg_t   instr0_freelist_resp,
    input  logic    instr1_freelist_req,
    output preg_t   instr1_freelist_resp,
    output logic    freelist_can_alloc,
    input  logic    free0_valid,
    input  preg_t   free0_preg,
    input  logic    free1_valid,
    input  preg_t   free1_preg,
    input  logic    commit0_alloc_valid,
    input  logic    commit1_alloc_valid,
    input  logic    flush_valid,
    output fl_ptr_t free_count
);

    preg_t   queue_q [DEPTH];
    preg_t   queue_d [DEPTH];
    fl_ptr_t spec_head_q, spec_head_d;
    fl_ptr_t arch_head_q, arch_head_d;
    fl_ptr_t tail_q, tail_d;

    logic [1:0] n_req;
    logic [1:0] n_alloc;
    logic [1:0] n_free;
    logic [1:0] n_commit;

    // Zero-latency responses and occupancy status from current state.
    always_comb begin
        free_count           = tail_q - spec_head_q;
        freelist_can_alloc   = (free_count >= fl_ptr_t'(2));
        instr0_freelist_resp = queue_q[ptr_idx(spec_head_q)];
        instr1_freelist_resp = queue_q[ptr_idx(ptr_add(spec_head_q, {1'b0, instr0_freelist_req}))];
    end

    // Next-state pointers and queue writes.
    always_comb begin
        n_req    = {1'b0, instr0_freelist_req} + {1'b0, instr1_freelist_req};
        n_free   = {1'b0, free0_valid} + {1'b0, free1_valid};
        n_commit = {1'b0, commit0_alloc_valid} + {1'b0, commit1_alloc_valid};

        // An over-ask is an error, but never pop past the tail.
        n_alloc = n_req;
        if (fl_ptr_t'(n_req) > free_count) begin
            n_alloc = free_count[1:0];
        end

        arch_head_d = ptr_add(arch_head_q, n_commit);
        spec_head_d = flush_valid ? arch_head_d : ptr_add(spec_head_q, n_alloc);
        tail_d      = ptr_add(tail_q, n_free);

        // Frees compact: the first valid release always lands at the tail.
        queue_d = queue_q;
        if (free0_valid || free1_valid) begin
            queue_d[ptr_idx(tail_q)] = free0_valid ? free0_preg : free1_preg;
        end
        if (free0_valid && free1_valid) begin
            queue_d[ptr_idx(ptr_add(tail_q, 2'd1))] = free1_preg;
        end
    end

    // State registers; reset restores a full list of pregs NUM_LREG..NUM_PREG-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                queue_q[i] <= preg_t'(int'(NUM_LREG) + i);
            end
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= {1'b1, {IDX_W{1'b0}}};
        end else begin
            queue_q     <= queue_d;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
        end
    end

`ifndef SYNTHESIS
    // Protocol checks: no over-allocation, no push beyond full.
    a_no_underflow: assert property (@(posedge clock) disable iff (reset)
        (flush_valid || fl_ptr_t'(n_req) <= free_count));
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        ({1'b0, free_count} + (PTR_W+1)'(n_free) <= (PTR_W+1)'(DEPTH)));
`endif

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for the free list: directed scenarios plus randomized
// traffic checked against an unbounded-counter reference model.
module tb_freelist;
    import freelist_pkg::*;

    logic    clock = 1'b0;
    logic    reset;
    logic    req0, req1;
    preg_t   resp0, resp1;
    logic    can_alloc;
    logic    f0v, f1v;
    preg_t   f0p, f1p;
    logic    c0, c1;
    logic    flush;
    fl_ptr_t fcnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: absolute (never-wrapping) counters over a ring of DEPTH.
    int m_mem [DEPTH];
    int m_spec, m_arch, m_tail;

    freelist dut (
        .clock                (clock),
        .reset                (reset),
        .instr0_freelist_req  (req0),
        .instr0_freelist_resp (resp0),
        .instr1_freelist_req  (req1),
        .instr1_freelist_resp (resp1),
        .freelist_can_alloc   (can_alloc),
        .free0_valid          (f0v),
        .free0_preg           (f0p),
        .free1_valid          (f1v),
        .free1_preg           (f1p),
        .commit0_alloc_valid  (c0),
        .commit1_alloc_valid  (c1),
        .flush_valid          (flush),
        .free_count           (fcnt)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = int'(NUM_LREG) + i;
        m_spec = 0;
        m_arch = 0;
        m_tail = int'(DEPTH);
    endfunction

    function automatic int m_fc();
        return m_tail - m_spec;
    endfunction

    function automatic int m_resp0();
        return m_mem[m_spec % int'(DEPTH)];
    endfunction

    function automatic int m_resp1();
        return m_mem[(m_spec + (req0 ? 1 : 0)) % int'(DEPTH)];
    endfunction

    // Apply one clock edge of the freelist rules to the model.
    function automatic void model_step();
        int fc;
        int nreq;
        fc   = m_fc();
        nreq = (req0 ? 1 : 0) + (req1 ? 1 : 0);
        if (f0v && f1v) begin
            m_mem[m_tail % int'(DEPTH)]       = int'(f0p);
            m_mem[(m_tail + 1) % int'(DEPTH)] = int'(f1p);
            m_tail += 2;
        end else if (f0v || f1v) begin
            m_mem[m_tail % int'(DEPTH)] = f0v ? int'(f0p) : int'(f1p);
            m_tail += 1;
        end
        m_arch += (c0 ? 1 : 0) + (c1 ? 1 : 0);
        if (flush) m_spec = m_arch;
        else       m_spec += (nreq < fc) ? nreq : fc;
    endfunction

    task automatic idle();
        req0 = 0; req1 = 0; f0v = 0; f1v = 0; f0p = '0; f1p = '0;
        c0 = 0; c1 = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (fcnt !== fl_ptr_t'(32)) begin
            failures++; $display("FAIL reset_free_count got=%0d exp=32", fcnt);
        end
        checks++;
        if (can_alloc !== 1'b1) begin
            failures++; $display("FAIL reset_can_alloc got=%0b exp=1", can_alloc);
        end
        checks++;
        if (resp0 !== preg_t'(32) || resp1 !== preg_t'(32)) begin
            failures++; $display("FAIL reset_resp got=%0d/%0d exp=32/32", resp0, resp1);
        end
    endtask

    task automatic test_dual_alloc();
        req0 = 1; req1 = 1;
        #1;
        checks++;
        if (resp0 !== preg_t'(32) || resp1 !== preg_t'(33)) begin
            failures++; $display("FAIL dual_resp got=%0d/%0d exp=32/33", resp0, resp1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (fcnt !== fl_ptr_t'(30) || resp0 !== preg_t'(34)) begin
            failures++; $display("FAIL dual_after got fc=%0d r0=%0d exp fc=30 r0=34", fcnt, resp0);
        end
    endtask

    task automatic test_drain();
        req0 = 1; req1 = 1;
        for (int i = 0; i < 14; i++) tick();
        idle();
        #1;
        checks++;
        if (fcnt !== fl_ptr_t'(2) || can_alloc !== 1'b1) begin
            failures++; $display("FAIL drain_two got fc=%0d ca=%0b exp fc=2 ca=1", fcnt, can_alloc);
        end
        req0 = 1; req1 = 1;
        tick();
        idle();
        #1;
        checks++;
        if (fcnt !== fl_ptr_t'(0) || can_alloc !== 1'b0) begin
            failures++; $display("FAIL drain_empty got fc=%0d ca=%0b exp fc=0 ca=0", fcnt, can_alloc);
        end
        checks++;
        if (resp0 !== preg_t'(32)) begin
            failures++; $display("FAIL drain_wrap_resp got=%0d exp=32", resp0);
        end
    endtask

    task automatic test_free_refill();
        f0v = 1; f0p = preg_t'(5); f1v = 1; f1p = preg_t'(7);
        tick();
        idle();
        #1;
        checks++;
        if (fcnt !== fl_ptr_t'(2) || can_alloc !== 1'b1) begin
            failures++; $display("FAIL refill_fc got fc=%0d ca=%0b exp fc=2 ca=1", fcnt, can_alloc);
        end
        req0 = 1; req1 = 1;
        #1;
        checks++;
        if (resp0 !== preg_t'(5) || resp1 !== preg_t'(7)) begin
            failures++; $display("FAIL refill_resp got=%0d/%0d exp=5/7", resp0, resp1);
        end
        tick();
        idle();
    endtask

    // Two pops and two pushes at free_count = 2 must not collide.
    task automatic test_full_pair();
        do_reset();
        req0 = 1; req1 = 1;
        for (int i = 0; i < 15; i++) tick();
        f0v = 1; f0p = preg_t'(11); f1v = 1; f1p = preg_t'(12);
        #1;
        checks++;
        if (resp0 !== preg_t'(62) || resp1 !== preg_t'(63)) begin
            failures++; $display("FAIL pair_resp got=%0d/%0d exp=62/63", resp0, resp1);
        end
        tick();
        idle();
        req0 = 1; req1 = 1;
        #1;
        checks++;
        if (fcnt !== fl_ptr_t'(2) || resp0 !== preg_t'(11) || resp1 !== preg_t'(12)) begin
            failures++;
            $display("FAIL pair_after got fc=%0d r=%0d/%0d exp fc=2 r=11/12", fcnt, resp0, resp1);
        end
        tick();
        idle();
    endtask

    task automatic test_flush_restore();
        do_reset();
        req0 = 1; req1 = 1;
        for (int i = 0; i < 3; i++) tick();
        idle();
        c0 = 1; c1 = 1;
        tick();
        idle();
        flush = 1;
        tick();
        idle();
        #1;
        checks++;
        if (fcnt !== fl_ptr_t'(30) || resp0 !== preg_t'(34)) begin
            failures++; $display("FAIL flush_restore got fc=%0d r0=%0d exp fc=30 r0=34", fcnt, resp0);
        end
    endtask

    task automatic test_flush_same_cycle();
        req0 = 1; req1 = 1; c0 = 1; f0v = 1; f0p = preg_t'(9); flush = 1;
        tick();
        idle();
        #1;
        checks++;
        if (fcnt !== fl_ptr_t'(30) || resp0 !== preg_t'(35)) begin
            failures++; $display("FAIL flush_same got fc=%0d r0=%0d exp fc=30 r0=35", fcnt, resp0);
        end
        // Drain to the slot the same-cycle free wrote.
        req0 = 1; req1 = 1;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (i == 14) begin
                checks++;
                if (resp1 !== preg_t'(9)) begin
                    failures++; $display("FAIL flush_same_pushed got=%0d exp=9", resp1);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        int fc, room, outst, n;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            fc    = m_fc();
            outst = m_spec - m_arch;
            room  = int'(DEPTH) - (m_tail - m_arch);
            if (fc >= 2) begin
                req0 = 1'($urandom_range(0, 1));
                req1 = 1'($urandom_range(0, 1));
            end
            n = $urandom_range(0, 2);
            if (n > outst) n = outst;
            c0 = (n >= 1); c1 = (n == 2);
            n = $urandom_range(0, 2);
            if (n > room) n = room;
            f0p = preg_t'($urandom_range(0, NUM_PREG - 1));
            f1p = preg_t'($urandom_range(0, NUM_PREG - 1));
            if (n == 2)      begin f0v = 1; f1v = 1; end
            else if (n == 1) begin f0v = ($urandom_range(0, 1) == 1); f1v = !f0v; end
            flush = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (resp0 !== preg_t'(m_resp0()) || resp1 !== preg_t'(m_resp1())) begin
                failures++;
                $display("FAIL rand_resp cyc=%0d got=%0d/%0d exp=%0d/%0d",
                         cyc, resp0, resp1, m_resp0(), m_resp1());
            end
            checks++;
            if (fcnt !== fl_ptr_t'(m_fc()) || can_alloc !== (m_fc() >= 2)) begin
                failures++;
                $display("FAIL rand_count cyc=%0d got fc=%0d ca=%0b exp fc=%0d",
                         cyc, fcnt, can_alloc, m_fc());
            end
            tick();
        end
        idle();
    endtask

    // Reset asserted between edges must take effect without a clock.
    task automatic test_reset_mid();
        req0 = 1; req1 = 1;
        for (int i = 0; i < 3; i++) tick();
        idle();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (fcnt !== fl_ptr_t'(32) || resp0 !== preg_t'(32) || resp1 !== preg_t'(32)) begin
            failures++;
            $display("FAIL reset_mid got fc=%0d r=%0d/%0d exp fc=32 r=32/32", fcnt, resp0, resp1);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        test_reset();
        test_dual_alloc();
        test_drain();
        test_free_refill();
        test_full_pair();
        test_flush_restore();
        test_flush_same_cycle();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freelist.md
Name: freelist

Overview:
- Physical-register free list for the dual-issue backend; it is the responder to rename's two per-cycle `instrN_freelist_req` / `instrN_freelist_resp` allocation requests.
- Circular queue of free preg indices:
  - speculative head pops on allocation;
  - tail pushes old_prd values released at commit;
  - architectural head advances at commit and restores the speculative head on flush.

Parameters:
- NUM_PREG, 64, physical register count; power of 2.
- NUM_LREG, 32, architectural register count; at reset, pregs 0..NUM_LREG-1 hold the identity mapping.
- DEPTH, NUM_PREG-NUM_LREG, queue entries; power of 2.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- instr0_freelist_req  in  1  slot0 allocation request.
- instr0_freelist_resp  out  PREG width  preg granted to slot0.
- instr1_freelist_req  in  1  slot1 allocation request.
- instr1_freelist_resp  out  PREG width  preg granted to slot1.
- freelist_can_alloc  out  1  at least 2 entries free; rename stalls when 0.
- free0_valid  in  1  commit slot0 releases old_prd.
- free0_preg  in  PREG width  preg released by commit slot0.
- free1_valid  in  1  commit slot1 releases old_prd.
- free1_preg  in  PREG width  preg released by commit slot1.
- commit0_alloc_valid  in  1  committing slot0 instr had allocated a prd.
- commit1_alloc_valid  in  1  committing slot1 instr had allocated a prd.
- flush_valid  in  1  redirect: discard all speculative allocations.
- free_count  out  log2(DEPTH)+1  entries currently free.

Behaviour:
- Storage and pointers:
  - Storage: DEPTH x PREG-width regs.
  - Pointers spec_head, arch_head and tail are each log2(DEPTH)+1 bits: index plus wrap bit.
  - free_count = tail - spec_head, modulo 2^(log2(DEPTH)+1).
- Reset (async, active-high):
  - queue[i] = NUM_LREG+i.
  - spec_head = 0, arch_head = 0.
  - tail = {1'b1, 0}, i.e. full.
  - Reset values of outputs: free_count = DEPTH; freelist_can_alloc = 1; instr0_freelist_resp = NUM_LREG; instr1_freelist_resp = NUM_LREG.
- Responses (combinational, zero latency):
  - resp0 = queue[spec_head].
  - resp1 = queue[spec_head + req0], i.e. the next entry when slot0 also allocates.
  - Responses are valid regardless of req; rename samples them in the same cycle.
- Allocation:
  - On the clock edge, spec_head += req0 + req1 (0/1/2).
  - Requests are legal only while freelist_can_alloc = 1, where freelist_can_alloc = (free_count >= 2).
  - A request with free_count < the number requested is a protocol error: simulation assertion fires; spec_head advances by at most free_count.
- Free:
  - queue[tail] <= first valid free preg; queue[tail+1] <= second.
  - tail += free0_valid + free1_valid.
  - Frees compact: free1 alone writes queue[tail].
- Commit: arch_head += commit0_alloc_valid + commit1_alloc_valid.
- Flush:
  - spec_head <= arch_head_next, i.e. arch_head including same-cycle commits.
  - Same-cycle allocation requests are ignored.
  - Same-cycle frees and commits are still applied (architectural).
- Overflow: free_count must never exceed DEPTH; a push beyond full triggers an assertion, and the write is still performed.
- Wrap-around: pointer indices wrap modulo DEPTH; the wrap bit distinguishes full from empty (equal indices, differing wrap = full).
- Simultaneous 2 alloc + 2 free with free_count = 2:
  - legal;
  - the pushes land in slots not being popped;
  - free_count stays 2.
- Reset mid-operation: all pointers and contents return to reset values immediately.

Decomposition:
- Constants in defines.sv:
  - NUM_PREG and NUM_LREG;
  - PREG_RANGE;
  - a new FL_PTR_RANGE.
- Helper: a pointer-add function that wraps with the wrap bit.
- No sub-module; a single flat module of about 150-200 lines.

Test Plan:
- Reset then idle:
  - free_count = 32; can_alloc = 1;
  - resp0 = 32, resp1 = 32 (no req0).
- req0 = req1 = 1 for 1 cycle:
  - that cycle: resp0 = 32, resp1 = 33;
  - next cycle: free_count = 30, resp0 = 34.
- Allocate 30 pregs (free_count = 2, can_alloc = 1), then 1 more pair:
  - free_count = 0; can_alloc = 0;
  - resp0 = 32 (wrapped index 0 still holds 32, unchanged).
- From the previous state:
  - free0 = 5, free1 = 7 -> free_count = 2, can_alloc = 1;
  - next allocation pair returns 5 then 7.
- Allocate 6 pregs, commit 2 (commit0/1_alloc_valid), then flush:
  - free_count goes back to 30;
  - resp0 = 34 (the entry after the two committed ones).
- Flush asserted in the same cycle as req0 = req1 = 1, commit0_alloc_valid = 1 and free0 = 9:
  - spec_head = arch_head + 1;
  - the alloc is ignored;
  - tail += 1 with queue entry = 9.
